// File: rtl/uart_rx_bit_sampler_if.sv
// uart_rx_bit_sampler_if: line, control and sample/count signals between the RX FSM and the bit sampler.
interface uart_rx_bit_sampler_if #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
);
    logic                  rx_in;
    logic [PRESCALE_W-1:0] prescale;
    logic                  cnt_en;
    logic                  dat_samp_en;
    logic                  sampled_bit;
    logic                  sample_valid;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  bit_done;

    modport master (
        output rx_in, prescale, cnt_en, dat_samp_en,
        input  sampled_bit, sample_valid, edge_cnt, bit_cnt, bit_done
    );

    modport slave (
        input  rx_in, prescale, cnt_en, dat_samp_en,
        output sampled_bit, sample_valid, edge_cnt, bit_cnt, bit_done
    );
endinterface

// File: rtl/uart_rx_bit_sampler.sv
// uart_rx_bit_sampler: synchronises rx, counts oversampling edges and bits, and majority-votes
// three mid-bit samples into one bit per bit period.
module uart_rx_bit_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input logic                  clk,
    input logic                  rst,
    uart_rx_bit_sampler_if.slave sb
);
    logic                  rx_s1_q, rx_s1_d, rx_sync_q, rx_sync_d;
    logic                  s0_q, s0_d, s1_q, s1_d;
    logic                  bit_q, bit_d, valid_q, valid_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_CNT_W-1:0]  bcnt_q, bcnt_d;
    logic [PRESCALE_W-1:0] p, m;
    logic                  legal, last, samp;

    // Unsupported prescale values fall back to 8x oversampling.
    assign legal = sb.prescale == PRESCALE_W'(8) || sb.prescale == PRESCALE_W'(16) ||
                   sb.prescale == PRESCALE_W'(32);
    assign p     = legal ? sb.prescale : PRESCALE_W'(8);
    assign m     = p >> 1;
    assign last  = edge_q == p - PRESCALE_W'(1);
    assign samp  = sb.dat_samp_en & sb.cnt_en;

    always_comb begin
        rx_s1_d   = sb.rx_in;
        rx_sync_d = rx_s1_q;
        edge_d    = !sb.cnt_en ? '0 : last ? '0 : edge_q + PRESCALE_W'(1);
        bcnt_d    = !sb.cnt_en ? '0 : (last && bcnt_q != '1) ? bcnt_q + BIT_CNT_W'(1) : bcnt_q;
        s0_d      = (samp && edge_q == m - PRESCALE_W'(1)) ? rx_sync_q : s0_q;
        s1_d      = (samp && edge_q == m) ? rx_sync_q : s1_q;
        valid_d   = samp && edge_q == m + PRESCALE_W'(1);
        bit_d     = valid_d ? (s0_q & s1_q) | (s1_q & rx_sync_q) | (s0_q & rx_sync_q) : bit_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1_q   <= 1'b1;
            rx_sync_q <= 1'b1;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            bit_q     <= 1'b1;
            valid_q   <= 1'b0;
            edge_q    <= '0;
            bcnt_q    <= '0;
        end else begin
            rx_s1_q   <= rx_s1_d;
            rx_sync_q <= rx_sync_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            bit_q     <= bit_d;
            valid_q   <= valid_d;
            edge_q    <= edge_d;
            bcnt_q    <= bcnt_d;
        end
    end

    assign sb.sampled_bit  = bit_q;
    assign sb.sample_valid = valid_q;
    assign sb.edge_cnt     = edge_q;
    assign sb.bit_cnt      = bcnt_q;
    assign sb.bit_done     = sb.cnt_en & last;
endmodule

// File: doc/uart_rx_bit_sampler.md
Name: uart_rx_bit_sampler

Overview:
UART RX oversampling front end. Synchronises the raw serial input and counts oversampling edges within each bit period. Counts bits within the frame and majority-votes three mid-bit samples into `sampled_bit`. The RX control FSM, start-glitch checker, parity checker, stop checker and deserializer all consume `sampled_bit`, `sample_valid` and the edge/bit counts.

Parameters:
PRESCALE_W, 6, width of prescale and edge_cnt; must be at least 6 so the value 32 fits.
BIT_CNT_W, 4, width of bit_cnt; bit_cnt saturates at 2^BIT_CNT_W-1.

Ports:
clk  input  1  system clock, oversampling rate (prescale x baud).
rst  input  1  reset, synchronous, active-low.
rx_in  input  1  raw asynchronous serial line, idle high.
prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
cnt_en  input  1  enables edge/bit counting; from the RX FSM.
dat_samp_en  input  1  enables sample capture and voting; from the RX FSM.
sampled_bit  output  1  majority-voted value of the current bit.
sample_valid  output  1  one-cycle strobe: sampled_bit was just updated.
edge_cnt  output  PRESCALE_W  oversampling edge index within the current bit, 0..P-1.
bit_cnt  output  BIT_CNT_W  bit index within the frame.
bit_done  output  1  high during the last edge of a bit (edge_cnt==P-1 with cnt_en).

Behaviour:
- Reset: all state updates only on posedge clk when rst==0.
  - Values at reset: sync flops=1, sampled_bit=1, sample_valid=0, edge_cnt=0, bit_cnt=0, sample regs s0/s1=1.
  - Reset mid-frame aborts the bit in progress; no partial sample_valid.
- Synchroniser: 2-flop chain, rx_in -> rx_s1 -> rx_sync. rx_sync lags rx_in by 2 cycles. Only rx_sync is sampled.
- Effective prescale P:
  - P = prescale when prescale is 8, 16 or 32; any other value gives P = 8.
  - m = P/2.
- Edge counter:
  - cnt_en=1: edge_cnt increments each cycle; when it is P-1 it wraps to 0 on the next edge.
  - cnt_en=0: edge_cnt <= 0 and bit_cnt <= 0 next cycle, regardless of their current values.
- Bit counter: increments on the edge where edge_cnt wraps (P-1 -> 0); saturates at all-ones (no wrap).
- bit_done: combinational, = cnt_en & (edge_cnt==P-1).
- Sampling is active only when dat_samp_en=1 and cnt_en=1:
  - edge_cnt==m-1: s0 <= rx_sync.
  - edge_cnt==m: s1 <= rx_sync.
  - edge_cnt==m+1: sampled_bit <= maj(s0, s1, rx_sync) and sample_valid <= 1.
  - Otherwise sample_valid <= 0.
  - Net effect: sampled_bit is new and sample_valid is high while edge_cnt==m+2. Exactly one pulse per bit.
- dat_samp_en=0: s0, s1 and sampled_bit hold; sample_valid=0.
- dat_samp_en deasserted between the m-1 and m+1 edges: no vote occurs for that bit; sampled_bit keeps its old value.
- Prescale change while cnt_en=1 is illegal (undefined count). The change must be made with cnt_en=0.
- Majority vote: maj(a,b,c) = ab | bc | ac.

Test Plan:
1. P=8, nominal zero bit: rst released; rx_in=0 held ≥2 cycles before cnt_en and dat_samp_en rise.
   -> edge_cnt goes 0..7; sample_valid high exactly during edge_cnt==6 with sampled_bit=0; bit_done high during edge_cnt==7; bit_cnt 0->1 when edge_cnt returns to 0.
2. P=16, single-sample glitch: rx_sync=1 except at edge 8 (m) where it is 0.
   -> sampled_bit=1, sample_valid at edge 10.
   Repeat with rx_sync=0 at edges 7 and 8 -> sampled_bit=0.
3. P=32, 11-bit frame of alternating 0/1, cnt_en held for 352 cycles.
   -> 11 sample_valid pulses, each at edge 18; sampled_bit sequence matches the driven bits; bit_cnt ends at 11.
   Then cnt_en=0 -> edge_cnt=0 and bit_cnt=0 the next cycle.
4. Saturation/illegal prescale: prescale=12 with cnt_en=1 -> counter wraps after 7 (P=8). Run 20 bits -> bit_cnt stops at 15.
5. Enable gating:
   - dat_samp_en=0 for a whole bit of rx=0, sampled_bit previously 1 -> no sample_valid; sampled_bit stays 1.
   - cnt_en dropped at edge_cnt==5 (P=16) -> no sample_valid for that bit.
6. Reset mid-bit: rst=0 at edge_cnt==m (P=16) -> next cycle edge_cnt=0, bit_cnt=0, sampled_bit=1, sample_valid=0; no pulse follows.
